// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// ----------------
// Multi-cycle controller that runs one ALU operation at a time for a single
// requester: IDLE -> READ -> EXEC -> WB -> IDLE.
//
// Optional feature macro: ALU_SEQ_OVERLAP_EN
//   Defined   : a new request may also be accepted in WB. The new op then goes
//               straight to READ (1 op per 3 cycles), and the value being
//               written back is forwarded into the new op's operands.
//   Undefined : requests are accepted only in IDLE (1 op per 4 cycles).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. The requester must hold req_valid and the request
// fields stable until that edge; req_ready never depends on req_valid.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_opcode/rd/ra/rb          operation and register indices
//   rf_ra_addr/rf_rb_addr        RF read addresses (sync read, data next cycle)
//   rf_ra_data/rf_rb_data        RF read data
//   alu_a/alu_b/alu_opcode/cin   ALU operand/control outputs
//   alu_c/alu_flags              ALU result and flags {Z,C,F,N,L}
//   rf_we/rf_wa/rf_wd            RF write port (one-cycle pulse in WB)
//   psr                          processor status register {Z,C,F,N,L}
//   done                         one-cycle pulse when an op retires
//   busy                         high whenever the FSM is not in IDLE

module alu_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_opcode,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [REG_AW-1:0] req_ra,
  input  logic [REG_AW-1:0] req_rb,
  output logic [REG_AW-1:0] rf_ra_addr,
  output logic [REG_AW-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [4:0]        alu_flags,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [4:0]        psr,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [REG_AW-1:0]   ra_q, ra_d;
  logic [REG_AW-1:0]   rb_q, rb_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [4:0]          flg_q, flg_d;
  logic [4:0]          psr_q, psr_d;

  logic                accept;
  logic                op_writes;
  logic                wr_en;

  // Compares and NOP produce flags only; everything else writes rd.
  always_comb begin
    op_writes = 1'b1;
    if (opcode_q == 8'h00 || opcode_q == 8'h0B || opcode_q == 8'h0C ||
        opcode_q[7:4] == 4'hB || opcode_q[7:4] == 4'hC) begin
      op_writes = 1'b0;
    end
  end

  assign wr_en = (state_q == S_WB) && op_writes;

`ifdef ALU_SEQ_OVERLAP_EN
  // Record of the write issued in the previous WB cycle. The RF reads the new
  // op's operands on the same edge that performs that write, so it returns
  // the stale value; these registers supply the fresh one instead.
  logic                fwd_we_q, fwd_we_d;
  logic [REG_AW-1:0]   fwd_wa_q, fwd_wa_d;
  logic [DATA_W-1:0]   fwd_wd_q, fwd_wd_d;

  assign req_ready = (state_q == S_IDLE) || (state_q == S_WB);
`else
  assign req_ready = (state_q == S_IDLE);
`endif

  assign accept = req_valid && req_ready;

  // Addresses go to the RF on the accept edge so data is ready during READ.
  assign rf_ra_addr = accept ? req_ra : ra_q;
  assign rf_rb_addr = accept ? req_rb : rb_q;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    flg_d    = flg_q;
    psr_d    = psr_q;
`ifdef ALU_SEQ_OVERLAP_EN
    fwd_we_d = fwd_we_q;
    fwd_wa_d = fwd_wa_q;
    fwd_wd_d = fwd_wd_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opcode_d = req_opcode;
          rd_d     = req_rd;
          ra_d     = req_ra;
          rb_d     = req_rb;
          state_d  = S_READ;
`ifdef ALU_SEQ_OVERLAP_EN
          fwd_we_d = 1'b0;
`endif
        end
      end
      S_READ: begin
`ifdef ALU_SEQ_OVERLAP_EN
        a_d = (fwd_we_q && fwd_wa_q == ra_q) ? fwd_wd_q : rf_ra_data;
        b_d = (fwd_we_q && fwd_wa_q == rb_q) ? fwd_wd_q : rf_rb_data;
`else
        a_d = rf_ra_data;
        b_d = rf_rb_data;
`endif
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_c;
        flg_d   = alu_flags;
        state_d = S_WB;
      end
      S_WB: begin
        if (opcode_q != 8'h00) begin
          psr_d = flg_q;
        end
        state_d = S_IDLE;
`ifdef ALU_SEQ_OVERLAP_EN
        fwd_we_d = wr_en;
        fwd_wa_d = rd_q;
        fwd_wd_d = res_q;
        if (accept) begin
          opcode_d = req_opcode;
          rd_d     = req_rd;
          ra_d     = req_ra;
          rb_d     = req_rb;
          state_d  = S_READ;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      flg_q    <= '0;
      psr_q    <= '0;
`ifdef ALU_SEQ_OVERLAP_EN
      fwd_we_q <= 1'b0;
      fwd_wa_q <= '0;
      fwd_wd_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
      psr_q    <= psr_d;
`ifdef ALU_SEQ_OVERLAP_EN
      fwd_we_q <= fwd_we_d;
      fwd_wa_q <= fwd_wa_d;
      fwd_wd_q <= fwd_wd_d;
`endif
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = opcode_q;
  // Carry-in comes from the live PSR, which already reflects the prior op.
  assign alu_cin    = (state_q == S_EXEC) && psr_q[3];
  assign rf_we      = wr_en;
  assign rf_wa      = (state_q == S_WB) ? rd_q : '0;
  assign rf_wd      = (state_q == S_WB) ? res_q : '0;
  assign psr        = psr_q;
  assign done       = (state_q == S_WB);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int DW = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [4:0]  psr;
    logic [31:0] cyc;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_opcode;
  logic [AW-1:0] req_rd, req_ra, req_rb;
  logic [AW-1:0] rf_ra_addr, rf_rb_addr;
  logic [DW-1:0] rf_ra_data, rf_rb_data;
  logic [DW-1:0] alu_a, alu_b;
  logic [7:0]    alu_opcode;
  logic          alu_cin;
  logic [DW-1:0] alu_c;
  logic [4:0]    alu_flags;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [4:0]    psr;
  logic          done;
  logic          busy;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] regs[16];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            we_cnt = 0;
  int            done_cnt = 0;
  bit            mon_pending = 1'b0;

  alu_op_sequencer #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rd(req_rd), .req_ra(req_ra), .req_rb(req_rb),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_c(alu_c), .alu_flags(alu_flags),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .psr(psr), .done(done), .busy(busy)
  );

  // ---------------- clock / reset, cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment: register file and ALU ----------------
  always @(posedge clk) begin
    rf_ra_data <= regs[rf_ra_addr];
    rf_rb_data <= regs[rf_rb_addr];
    if (rf_we) regs[rf_wa] <= rf_wd;
  end

  // Small ALU stand-in: ADD, ADDU, ADDC, CMP; anything else returns zeros.
  logic [16:0] sum;
  always_comb begin
    sum       = {1'b0, alu_a} + {1'b0, alu_b} +
                {16'd0, (alu_opcode == 8'h07) ? alu_cin : 1'b0};
    alu_c     = '0;
    alu_flags = '0;
    case (alu_opcode)
      8'h05, 8'h07: begin
        alu_c     = sum[15:0];
        alu_flags = {sum[15:0] == 16'd0, sum[16],
                     (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]),
                     sum[15], 1'b0};
      end
      8'h06: begin
        alu_c     = sum[15:0];
        alu_flags = {sum[15:0] == 16'd0, sum[16], 3'b000};
      end
      8'h0B: begin
        alu_c     = alu_a - alu_b;
        alu_flags = {alu_a == alu_b, 3'b000, $signed(alu_a) < $signed(alu_b)};
      end
      default: ;
    endcase
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) if (rf_we) we_cnt++;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          mon_pending = 1'b1;
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), e.cyc);
          check("rf_we", 32'(rf_we), 32'(e.we));
          if (e.we) begin
            check("rf_wa", 32'(rf_wa), 32'(e.wa));
            check("rf_wd", 32'(rf_wd), 32'(e.wd));
          end
          @(negedge clk);
          check("psr", 32'(psr), 32'(e.psr));
          mon_pending = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge. Returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] ra,
                      input logic [3:0] rb, input logic we, input logic [15:0] wd,
                      input logic [4:0] p, input bit drop,
                      output int acc_cyc, output logic we_at_acc);
    exp_t e;
    bit   ok = 1'b0;
    req_valid  = 1'b1;
    req_opcode = op;
    req_rd     = rd;
    req_ra     = ra;
    req_rb     = rb;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    acc_cyc   = cyc;
    we_at_acc = rf_we;
    if (!ok) fail_now("accept_timeout");
    else begin
      e.we = we; e.wa = rd; e.wd = wd; e.psr = p; e.cyc = 32'(cyc + 3);
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (drop) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy && exp_q.size() == 0 && !mon_pending) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int   a1, a2;
    logic w1, w2;
    int   we_before, done_before;

    for (int i = 0; i < 16; i++) regs[i] = '0;
    regs[1] = 16'h7FFF; regs[2] = 16'h0001; regs[4] = 16'hFFFF;
    regs[5] = 16'h0003; regs[6] = 16'h0004; regs[7] = 16'h1234;
    regs[8] = 16'h1234; regs[14] = 16'h5555;

    rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0;
    req_rd = '0; req_ra = '0; req_rb = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_rf_we",     32'(rf_we),     32'd0);
    check("rst_psr",       32'(psr),       32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: signed overflow ADD
    send(8'h05, 4'd3, 4'd1, 4'd2, 1'b1, 16'h8000, 5'b00110, 1'b1, a1, w1);
    wait_idle();

    // 2: ADDU carry out, then ADDC consumes it
    send(8'h06, 4'd9, 4'd4, 4'd2, 1'b1, 16'h0000, 5'b11000, 1'b1, a1, w1);
    wait_idle();
    send(8'h07, 4'd10, 4'd5, 4'd6, 1'b1, 16'h0008, 5'b00000, 1'b1, a1, w1);
    @(negedge clk);
    check("addc_cin", 32'(alu_cin), 32'd1);
    wait_idle();

    // 3: compares write nothing
    send(8'h0B, 4'd11, 4'd4, 4'd2, 1'b0, 16'h0000, 5'b00001, 1'b1, a1, w1);
    wait_idle();
    send(8'h0B, 4'd11, 4'd7, 4'd8, 1'b0, 16'h0000, 5'b10000, 1'b1, a1, w1);
    wait_idle();

    // 4: NOP leaves psr alone
    send(8'h00, 4'd12, 4'd1, 4'd2, 1'b0, 16'h0000, 5'b10000, 1'b1, a1, w1);
    wait_idle();

    // 5: reset during EXEC abandons the op
    we_before   = we_cnt;
    done_before = done_cnt;
    req_valid = 1'b1; req_opcode = 8'h05; req_rd = 4'd13; req_ra = 4'd1; req_rb = 4'd2;
    while (!req_ready) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_psr",       32'(psr),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_write", 32'(we_cnt),   32'(we_before));
    check("rst_no_done",  32'(done_cnt), 32'(done_before));
    send(8'h05, 4'd13, 4'd5, 4'd6, 1'b1, 16'h0007, 5'b00000, 1'b1, a1, w1);
    wait_idle();

    // immediate compare forms, undefined opcode
    send(8'hB3, 4'd12, 4'd7, 4'd8, 1'b0, 16'h0000, 5'b00000, 1'b1, a1, w1);
    wait_idle();
    send(8'hC5, 4'd12, 4'd7, 4'd8, 1'b0, 16'h0000, 5'b00000, 1'b1, a1, w1);
    wait_idle();
    send(8'hEE, 4'd14, 4'd1, 4'd2, 1'b1, 16'h0000, 5'b00000, 1'b1, a1, w1);
    wait_idle();

    // rd == ra: second op sees the first op's write
    send(8'h05, 4'd5, 4'd5, 4'd6, 1'b1, 16'h0007, 5'b00000, 1'b1, a1, w1);
    wait_idle();
    send(8'h05, 4'd5, 4'd5, 4'd6, 1'b1, 16'h000B, 5'b00000, 1'b1, a1, w1);
    wait_idle();

    // 6: back-to-back with req_valid held
    send(8'h05, 4'd15, 4'd1, 4'd2, 1'b1, 16'h8000, 5'b00110, 1'b0, a1, w1);
    send(8'h05, 4'd14, 4'd15, 4'd0, 1'b1, 16'h8000, 5'b00010, 1'b1, a2, w2);
    @(negedge clk);
    check("b2b_alu_a", 32'(alu_a), 32'h8000);
`ifdef ALU_SEQ_OVERLAP_EN
    check("b2b_spacing", 32'(a2 - a1), 32'd3);
    check("b2b_we_at_accept", 32'(w2), 32'd1);
`else
    check("b2b_spacing", 32'(a2 - a1), 32'd4);
    check("b2b_we_at_accept", 32'(w2), 32'd0);
`endif
    wait_idle();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_total", 32'(done_cnt), 32'd14);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
